event_blinker: RTL and testbench
================================

EVENT_BLINKER -- requirements
Module: event_blinker

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 1_500_000: led active time per blink, in clk cycles; legal range >= 1.
REQ-002 SHALL have parameter OFF_CYCLES, default 1_500_000: forced led inactive gap after each blink, in clk cycles; legal range >= 1.
REQ-003 SHALL have parameter MAX_PENDING, default 3: depth of the queued-event counter; legal range >= 1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts led_out only.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic on posedge clk.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port event_in, input, 1 bit: event request, one event per cycle high, clk-synchronous (e.g. edge-mode debounced button).
REQ-008 SHALL have port clr_ovf, input, 1 bit: clears the overflow flag.
REQ-009 SHALL have port led_out, output, 1 bit: visible indicator, registered.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port pending, output, clog2(MAX_PENDING+1) bits: number of queued events not yet blinked.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped event.

Function
REQ-013 SHALL implement FSM states IDLE, ON, OFF; one down-counter of width clog2(max(ON_CYCLES,OFF_CYCLES)+1) times both phases.
REQ-014 IDLE with event_in=1 SHALL enter ON next cycle, load counter with ON_CYCLES, leave pending unchanged.
REQ-015 ON SHALL last exactly ON_CYCLES cycles, then enter OFF for exactly OFF_CYCLES cycles.
REQ-016 Led SHALL be active exactly while the state is ON: internal led = (state==ON); led_out = led XOR ACTIVE_LOW; 1-cycle latency from event_in to led active.
REQ-017 On the last OFF cycle, the FSM SHALL enter ON if pending>0 (pending decrements) or event_in=1 (consumed directly), else IDLE.
REQ-018 event_in=1 in ON or OFF, not consumed per REQ-017, SHALL increment pending.
REQ-019 On the last OFF cycle with pending>0 and event_in=1: increment and decrement SHALL cancel; pending unchanged; ON entered.
REQ-020 If an increment is due at pending==MAX_PENDING, the event SHALL be dropped and overflow set next cycle; pending stays MAX_PENDING.
REQ-021 overflow SHALL stay high until clr_ovf=1 or reset; a drop coincident with clr_ovf SHALL leave overflow=1 (set wins).
REQ-022 pending SHALL never wrap and never underflow; the counter SHALL never wrap.
REQ-023 busy SHALL be high from the cycle after an accepted IDLE event until the return to IDLE.
REQ-024 Back-to-back blinks SHALL have exactly OFF_CYCLES inactive cycles between ON phases, with no extra idle cycle.

Reset
REQ-025 reset SHALL override all other inputs in its cycle.
REQ-026 After reset: state IDLE, counter 0, pending 0, overflow 0, busy 0, led_out = ACTIVE_LOW.
REQ-027 reset asserted mid-ON or mid-OFF SHALL abort the blink and discard the queue; led inactive the next cycle.
REQ-028 event_in during reset SHALL be ignored.

Verification
Bench parameters: ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=2, ACTIVE_LOW=0 unless stated; cycle n = posedge index after reset release.
REQ-029 Single event at cycle 0 -> led_out=1 cycles 1-4, 0 cycles 5-7; busy=1 cycles 1-7; IDLE and busy=0 at cycle 8; pending=0 throughout.
REQ-030 Events at cycles 0, 2, 3, 4 -> pending 1 after cycle 2, 2 after cycle 3; cycle 4 event dropped, overflow=1 from cycle 5; exactly 3 blinks; ON phases start at 1, 8, 15; overflow still 1 afterwards; clr_ovf pulse -> overflow 0 next cycle.
REQ-031 Event at cycle 0, second event at cycle 7 (last OFF cycle) with pending=0 -> second ON starts cycle 8; pending stays 0.
REQ-032 Event at cycle 0, second at cycle 2, third at cycle 7 -> pending 1 from cycle 3, stays 1 through cycle 8 (cancel); third blink ON starts cycle 15.
REQ-033 Event at cycle 0, event at cycle 2, reset at cycle 3 -> cycle 4: led_out=0, pending=0, busy=0; no further blinks.
REQ-034 ACTIVE_LOW=1, single event at cycle 0 -> led_out=1 at reset and idle, 0 cycles 1-4, 1 from cycle 5.

Source files
------------

// File: rtl/event_blinker.sv
// Event blinker: each accepted event produces one LED blink of ON_CYCLES followed by a
// forced OFF_CYCLES gap. Events arriving mid-blink are queued up to MAX_PENDING; any
// further event is dropped and latched in a sticky overflow flag.
module event_blinker #(
  parameter int unsigned ON_CYCLES   = 1_500_000,
  parameter int unsigned OFF_CYCLES  = 1_500_000,
  parameter int unsigned MAX_PENDING = 3,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               event_in,
  input  logic                               clr_ovf,
  output logic                               led_out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int unsigned CntMax = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned CW     = $clog2(CntMax + 1);
  localparam int unsigned PW     = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] OnLoad  = CW'(ON_CYCLES);
  localparam logic [CW-1:0] OffLoad = CW'(OFF_CYCLES);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [PW-1:0] PendMax = PW'(MAX_PENDING);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   pending_q;
  logic            overflow_q;
  logic            led_q;

  logic            last_off;
  logic            queue_evt;
  logic            pend_inc;
  logic            pend_drop;

  // Classify the incoming event: consumed by the FSM, queued, or dropped when full.
  always_comb begin
    last_off  = (state_q == StOff) && (cnt_q == CntOne);
    // On the last OFF cycle the event either starts the next blink directly or
    // cancels against the queued one being consumed, so it is never queued there.
    queue_evt = event_in && (state_q != StIdle) && !last_off;
    pend_inc  = queue_evt && (pending_q != PendMax);
    pend_drop = queue_evt && (pending_q == PendMax);
  end

  // Blink FSM with shared phase counter, event queue, overflow flag and registered LED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      led_q      <= ACTIVE_LOW;
    end else begin
      // A drop in the same cycle as a clear keeps the flag set.
      if (pend_drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end

      if (pend_inc) begin
        pending_q <= pending_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (event_in) begin
            state_q <= StOn;
            cnt_q   <= OnLoad;
            led_q   <= ~ACTIVE_LOW;
          end
        end
        StOn: begin
          if (cnt_q == CntOne) begin
            state_q <= StOff;
            cnt_q   <= OffLoad;
            led_q   <= ACTIVE_LOW;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StOff: begin
          if (cnt_q == CntOne) begin
            if (pending_q != '0) begin
              state_q <= StOn;
              cnt_q   <= OnLoad;
              led_q   <= ~ACTIVE_LOW;
              // A simultaneous new event replaces the consumed one.
              if (!event_in) begin
                pending_q <= pending_q - 1'b1;
              end
            end else if (event_in) begin
              state_q <= StOn;
              cnt_q   <= OnLoad;
              led_q   <= ~ACTIVE_LOW;
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          led_q   <= ACTIVE_LOW;
        end
      endcase
    end
  end

  assign led_out  = led_q;
  assign busy     = (state_q != StIdle);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with ON=4, OFF=3, MAX_PENDING=2. Expected waveforms
// are hand-written bit masks where bit n is the value during cycle n after reset release.
module tb_event_blinker;

  logic       clk = 1'b0;
  logic       reset;
  logic       event_in;
  logic       clr_ovf;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;
  logic       led_out_al;
  logic       busy_al;
  logic [1:0] pending_al;
  logic       overflow_al;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  event_blinker #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .MAX_PENDING(2),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .event_in (event_in),
    .clr_ovf  (clr_ovf),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  event_blinker #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .MAX_PENDING(2),
    .ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk      (clk),
    .reset    (reset),
    .event_in (event_in),
    .clr_ovf  (clr_ovf),
    .led_out  (led_out_al),
    .busy     (busy_al),
    .pending  (pending_al),
    .overflow (overflow_al)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reset, then drive per-cycle stimulus masks and compare every output each cycle.
  task automatic run_test(input string name, input int ncyc,
                          input logic [31:0] ev, input logic [31:0] rst,
                          input logic [31:0] clr, input logic [31:0] exp_led,
                          input logic [31:0] exp_busy, input logic [31:0] exp_p0,
                          input logic [31:0] exp_p1, input logic [31:0] exp_ovf,
                          input bit chk_al);
    reset    = 1'b1;
    event_in = 1'b1;  // must be ignored while in reset
    clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      check($sformatf("%s led c%0d", name, c), {31'b0, led_out}, {31'b0, exp_led[c]});
      check($sformatf("%s busy c%0d", name, c), {31'b0, busy}, {31'b0, exp_busy[c]});
      check($sformatf("%s pending c%0d", name, c), {30'b0, pending},
            {30'b0, exp_p1[c], exp_p0[c]});
      check($sformatf("%s overflow c%0d", name, c), {31'b0, overflow}, {31'b0, exp_ovf[c]});
      if (chk_al) begin
        check($sformatf("%s led_al c%0d", name, c), {31'b0, led_out_al},
              {31'b0, ~exp_led[c]});
      end
      reset    = rst[c];
      event_in = ev[c];
      clr_ovf  = clr[c];
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    event_in = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    event_in = 1'b0;
    clr_ovf  = 1'b0;

    // Single blink; inverted instance checked alongside.
    run_test("single", 10, 32'h1, 32'h0, 32'h0,
             32'h1E, 32'hFE, 32'h0, 32'h0, 32'h0, 1'b1);

    // Queue fills, fourth event dropped, three blinks, then overflow cleared.
    run_test("queue", 24, 32'h1D, 32'h0, 32'h40_0000,
             32'h7_8F1E, 32'h3F_FFFE, 32'h7F08, 32'hF0, 32'h7F_FFE0, 1'b0);

    // Event on the last OFF cycle with an empty queue starts the next blink directly.
    run_test("direct", 16, 32'h81, 32'h0, 32'h0,
             32'hF1E, 32'h7FFE, 32'h0, 32'h0, 32'h0, 1'b0);

    // Event on the last OFF cycle with a queued event cancels the decrement.
    run_test("cancel", 24, 32'h85, 32'h0, 32'h0,
             32'h7_8F1E, 32'h3F_FFFE, 32'h7FF8, 32'h0, 32'h0, 1'b0);

    // Reset mid-ON aborts the blink and drops the queue; event during reset ignored.
    run_test("abort", 12, 32'hD, 32'h8, 32'h0,
             32'hE, 32'hE, 32'h8, 32'h0, 32'h0, 1'b0);

    // Drop coincident with clr_ovf: set wins.
    run_test("setwins", 10, 32'h1D, 32'h0, 32'h10,
             32'h31E, 32'h3FE, 32'h308, 32'hF0, 32'h3E0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
